// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch/execute definitions: memory depth default, opcode constants,
// fetch state encoding and the buffered {pc, instr} entry type.
package instr_fetch_unit_pkg;

   localparam int INSTR_NUM_DFLT = 256;
   localparam int BUF_DEPTH_DFLT = 2;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Byte address lies inside the instruction memory; 33 bits so pc+4 never wraps.
   function automatic logic pc_in_range(input logic [32:0] pc, input int unsigned instr_num);
      return pc < (33'(instr_num) << 2);
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus: instruction-memory request side, redirect input and the
// valid/ready instruction stream towards the consumer.
interface instr_fetch_unit_if
   import instr_fetch_unit_pkg::*;
#(
   parameter int INSTR_NUM = INSTR_NUM_DFLT
);
   localparam int AW = $clog2(INSTR_NUM);

   logic          imem_req_o;
   logic [AW-1:0] imem_addr_o;
   logic [31:0]   imem_data_i;
   logic          redirect_i;
   logic [31:0]   redirect_pc_i;
   logic [31:0]   instr_o;
   logic [31:0]   pc_o;
   logic          valid_o;
   logic          ready_i;
   logic          halt_o;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_data_i,
      input  redirect_i,
      input  redirect_pc_i,
      output instr_o,
      output pc_o,
      output valid_o,
      input  ready_i,
      output halt_o
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_data_i,
      output redirect_i,
      output redirect_pc_i,
      input  instr_o,
      input  pc_o,
      input  valid_o,
      output ready_i,
      input  halt_o
   );

endinterface

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// Two-entry {pc, instr} FIFO; slot0 is always the head so the head entry and
// its valid flag come straight from registers.
module fetch_buffer
   import instr_fetch_unit_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t wr_entry,
   output fetch_entry_t head_entry,
   output logic         head_valid,
   output logic [1:0]   count
);

   fetch_entry_t slot0_r;
   fetch_entry_t slot1_r;
   fetch_entry_t slot0_s;
   fetch_entry_t slot1_s;
   logic         vld0_r;
   logic         vld1_r;
   logic         vld0_s;
   logic         vld1_s;
   logic         pop_s;

   // Next-state of both slots for every push/pop combination.
   always_comb begin
      pop_s   = pop & vld0_r;
      slot0_s = slot0_r;
      slot1_s = slot1_r;
      vld0_s  = vld0_r;
      vld1_s  = vld1_r;
      case ({pop_s, push})
         2'b10: begin
            slot0_s = slot1_r;
            vld0_s  = vld1_r;
            vld1_s  = 1'b0;
         end
         2'b01: begin
            if (vld0_r) begin
               slot1_s = wr_entry;
               vld1_s  = 1'b1;
            end else begin
               slot0_s = wr_entry;
               vld0_s  = 1'b1;
            end
         end
         2'b11: begin
            // Head leaves while a new word arrives: the new word lands behind the survivor.
            if (vld1_r) begin
               slot0_s = slot1_r;
               slot1_s = wr_entry;
               vld1_s  = 1'b1;
            end else begin
               slot0_s = wr_entry;
               vld0_s  = 1'b1;
               vld1_s  = 1'b0;
            end
         end
         default: begin
            vld0_s = vld0_r;
            vld1_s = vld1_r;
         end
      endcase
   end

   // Slot registers; flush only drops the valid flags.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         slot0_r <= fetch_entry_t'(64'd0);
         slot1_r <= fetch_entry_t'(64'd0);
         vld0_r  <= 1'b0;
         vld1_r  <= 1'b0;
      end else if (flush) begin
         vld0_r  <= 1'b0;
         vld1_r  <= 1'b0;
      end else begin
         slot0_r <= slot0_s;
         slot1_r <= slot1_s;
         vld0_r  <= vld0_s;
         vld1_r  <= vld1_s;
      end
   end

   assign head_entry = slot0_r;
   assign head_valid = vld0_r;
   assign count      = {1'b0, vld0_r} + {1'b0, vld1_r};

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word reads to a synchronous memory, buffers
// returns in a 2-entry FIFO and streams {pc, instr} to the consumer.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int INSTR_NUM = INSTR_NUM_DFLT,
   parameter int BUF_DEPTH = BUF_DEPTH_DFLT
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   instr_fetch_unit_if.master   bus
);

   localparam int         AW      = $clog2(INSTR_NUM);
   localparam logic [1:0] DEPTH_C = 2'(BUF_DEPTH);

   fetch_state_e state_r;
   logic [31:0]  fetch_pc_r;
   logic [31:0]  rsp_pc_r;
   logic         rsp_r;
   logic [31:0]  redirect_pc_s;
   logic [32:0]  pc_plus4_s;
   logic [1:0]   count_s;
   logic [1:0]   occ_s;
   logic         room_s;
   logic         req_s;
   logic         push_s;
   logic         pop_s;
   logic         head_valid_s;
   fetch_entry_t head_s;
   fetch_entry_t wr_entry_s;

   // Request is combinational so a slot freed by this cycle's transfer is refilled at once,
   // which is what sustains one instruction per cycle with only two entries.
   always_comb begin
      occ_s         = count_s + {1'b0, rsp_r};
      pop_s         = head_valid_s & bus.ready_i;
      room_s        = (occ_s < DEPTH_C) || ((occ_s == DEPTH_C) && pop_s);
      req_s         = rst_i && (state_r == ST_RUN) && !bus.redirect_i && room_s;
      push_s        = rsp_r && !bus.redirect_i;
      pc_plus4_s    = {1'b0, fetch_pc_r} + 33'd4;
      redirect_pc_s = bus.redirect_pc_i & 32'hFFFF_FFFC;
      wr_entry_s    = '{pc: rsp_pc_r, instr: bus.imem_data_i};
   end

   // RUN/HALT control, fetch PC and the one-deep memory response tracker.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_r    <= ST_RUN;
         fetch_pc_r <= 32'd0;
         rsp_r      <= 1'b0;
         rsp_pc_r   <= 32'd0;
      end else if (bus.redirect_i) begin
         fetch_pc_r <= redirect_pc_s;
         rsp_r      <= 1'b0;
         state_r    <= pc_in_range({1'b0, redirect_pc_s}, INSTR_NUM) ? ST_RUN : ST_HALT;
      end else begin
         rsp_r <= req_s;
         if (req_s) begin
            rsp_pc_r   <= fetch_pc_r;
            fetch_pc_r <= pc_plus4_s[31:0];
            state_r    <= pc_in_range(pc_plus4_s, INSTR_NUM) ? ST_RUN : ST_HALT;
         end
      end
   end

   fetch_buffer u_fetch_buffer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push       (push_s),
      .pop        (pop_s),
      .flush      (bus.redirect_i),
      .wr_entry   (wr_entry_s),
      .head_entry (head_s),
      .head_valid (head_valid_s),
      .count      (count_s)
   );

   assign bus.imem_req_o  = req_s;
   assign bus.imem_addr_o = fetch_pc_r[AW+1:2];
   assign bus.instr_o     = head_s.instr;
   assign bus.pc_o        = head_s.pc;
   assign bus.valid_o     = head_valid_s;
   assign bus.halt_o      = (state_r == ST_HALT);

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter INSTR_NUM, default 256: instruction memory depth in 32-bit words.
REQ-002 Parameter BUF_DEPTH, default 2: output buffer entries, fixed at 2 for this revision.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-low.
REQ-005 imem_req_o  output  1  read request to synchronous instruction memory.
REQ-006 imem_addr_o  output  log2(INSTR_NUM)  word index (pc/4).
REQ-007 imem_data_i  input  32  read data, valid exactly one cycle after imem_req_o.
REQ-008 redirect_i  input  1  one-cycle pulse: flush and restart fetch at redirect_pc_i.
REQ-009 redirect_pc_i  input  32  byte address of new fetch target.
REQ-010 instr_o  output  32  instruction at buffer head.
REQ-011 pc_o  output  32  byte address of instr_o.
REQ-012 valid_o  output  1  instr_o/pc_o valid.
REQ-013 ready_i  input  1  consumer accepts; transfer when valid_o and ready_i high at rising edge.
REQ-014 halt_o  output  1  fetch PC beyond last word; no further requests.

Function
REQ-015 State machine: RUN (issuing), HALT (fetch PC >= INSTR_NUM*4); RUN->HALT when fetch PC would exceed range; HALT->RUN only on redirect_i with in-range target.
REQ-016 Fetch PC increments by 4 per issued request; 32-bit unsigned arithmetic, no wrap to 0 (range check precedes issue).
REQ-017 Request issued in a cycle only if RUN and (buffer count + in-flight) < 2, or == 2 with a transfer this cycle.
REQ-018 Returned data written to buffer tail with its PC the cycle after the request; FIFO order preserved.
REQ-019 valid_o registered: word requested in cycle N appears on instr_o no earlier than cycle N+2.
REQ-020 Sustained throughput one instruction per cycle while ready_i held high.
REQ-021 instr_o/pc_o stable while valid_o high and ready_i low; no entry dropped or duplicated.
REQ-022 redirect_i: buffer cleared, in-flight return discarded, valid_o low next cycle, fetch PC = {redirect_pc_i[31:2],2'b00}, request at that PC next cycle if in range.
REQ-023 Redirect coincident with transfer: transfer counts as completed, then flush applies.
REQ-024 Redirect coincident with memory return: returned word discarded.
REQ-025 Redirect to out-of-range target: enter HALT, no request, halt_o high next cycle.
REQ-026 In HALT, buffered entries still drain normally; halt_o independent of valid_o.

Reset
REQ-027 While rst_i low at a rising edge: fetch PC=0, buffer empty, in-flight cleared, state RUN.
REQ-028 Reset values: valid_o=0, imem_req_o=0, halt_o=0, instr_o=0, pc_o=0, imem_addr_o=0.
REQ-029 Reset mid-operation discards buffer and in-flight data; first request at word 0 in first cycle rst_i high.

Structure
REQ-030 Shared package holds INSTR_NUM, opcode/func constants and the RUN/HALT state encoding used by fetch and execute.
REQ-031 One sub-module, fetch_buffer: 2-entry FIFO of {pc,instr} with push/pop/flush and count.
REQ-032 Instruction memory array external; this block only drives address and request.

Verification
REQ-033 Reset release, ready_i=1, memory word k = k -> instr_o 0,1,2,... with pc_o 0,4,8, first valid cycle 2, one per cycle.
REQ-034 ready_i low cycles 5-9 -> valid_o held, instr_o frozen, no more than 2 outstanding plus buffered, resumes without loss or duplicate.
REQ-035 redirect_i with redirect_pc_i=0x40 while buffer full -> next accepted instr word 16, pc_o 0x40; no stale word after redirect.
REQ-036 redirect_pc_i=0x43 -> fetch from 0x40.
REQ-037 Run to pc 0x3FC (INSTR_NUM=256) -> last pc_o 0x3FC, halt_o=1, imem_req_o stays 0; redirect to 0x0 -> resumes at word 0, halt_o=0.
REQ-038 rst_i low for one cycle mid-stream with buffer full -> valid_o=0 next cycle, restart at pc 0.
